// File: rtl/one_bit_comparator.sv
// -----------------------------------------------------------------------------
// one_bit_comparator
//   Registered 1-bit magnitude comparator with optional result statistics.
//   o1 = A>B, o2 = A==B, o3 = A<B, captured on clk edges where in_valid=1.
//   out_valid latches high on the first capture after reset.
//
//   Build option: define ONE_BIT_COMPARATOR_STATS_EN to include the three
//   saturating result counters and the clr_stats clear. Without it the counter
//   ports are driven to zero and clr_stats is ignored.
//
//   rst is asynchronous and active-high; all outputs come straight from flops.
// -----------------------------------------------------------------------------
module one_bit_comparator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             in_valid,
   input  logic             clr_stats,
   output logic             o1,
   output logic             o2,
   output logic             o3,
   output logic             out_valid,
   output logic [CNT_W-1:0] cnt_gt,
   output logic [CNT_W-1:0] cnt_eq,
   output logic [CNT_W-1:0] cnt_lt
);

   // Combinational comparison of the current operands.
   logic gt_w;
   logic eq_w;
   logic lt_w;

   assign gt_w = A & ~B;
   assign eq_w = ~(A ^ B);
   assign lt_w = ~A & B;

   // Result and valid registers.
   logic o1_q, o1_d;
   logic o2_q, o2_d;
   logic o3_q, o3_d;
   logic out_valid_q, out_valid_d;

   // Next-state: capture a fresh comparison when in_valid, otherwise hold.
   always_comb begin
      o1_d        = o1_q;
      o2_d        = o2_q;
      o3_d        = o3_q;
      out_valid_d = out_valid_q;
      if (in_valid) begin
         o1_d        = gt_w;
         o2_d        = eq_w;
         o3_d        = lt_w;
         out_valid_d = 1'b1;
      end
   end

   // Result registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o1_q        <= 1'b0;
         o2_q        <= 1'b0;
         o3_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         o1_q        <= o1_d;
         o2_q        <= o2_d;
         o3_q        <= o3_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign o1        = o1_q;
   assign o2        = o2_q;
   assign o3        = o3_q;
   assign out_valid = out_valid_q;

`ifdef ONE_BIT_COMPARATOR_STATS_EN
   // All-ones value at which each counter sticks.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
   logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
   logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;

   // Next-state: clear has priority over counting; otherwise bump the one
   // counter that matches this capture, stopping at CNT_MAX.
   always_comb begin
      cnt_gt_d = cnt_gt_q;
      cnt_eq_d = cnt_eq_q;
      cnt_lt_d = cnt_lt_q;
      if (clr_stats) begin
         cnt_gt_d = '0;
         cnt_eq_d = '0;
         cnt_lt_d = '0;
      end else if (in_valid) begin
         if (gt_w && (cnt_gt_q != CNT_MAX)) begin
            cnt_gt_d = cnt_gt_q + 1'b1;
         end
         if (eq_w && (cnt_eq_q != CNT_MAX)) begin
            cnt_eq_d = cnt_eq_q + 1'b1;
         end
         if (lt_w && (cnt_lt_q != CNT_MAX)) begin
            cnt_lt_d = cnt_lt_q + 1'b1;
         end
      end
   end

   // Counter registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_gt_q <= '0;
         cnt_eq_q <= '0;
         cnt_lt_q <= '0;
      end else begin
         cnt_gt_q <= cnt_gt_d;
         cnt_eq_q <= cnt_eq_d;
         cnt_lt_q <= cnt_lt_d;
      end
   end

   assign cnt_gt = cnt_gt_q;
   assign cnt_eq = cnt_eq_q;
   assign cnt_lt = cnt_lt_q;
`else
   // Statistics compiled out: counters read as zero and the clear is unused.
   logic unused_clr_stats;
   assign unused_clr_stats = clr_stats;

   assign cnt_gt = '0;
   assign cnt_eq = '0;
   assign cnt_lt = '0;
`endif

endmodule

// File: tb/tb_one_bit_comparator.sv
// -----------------------------------------------------------------------------
// tb_one_bit_comparator
//   Scoreboard bench: every driven cycle pushes the expected output vector
//   {o1,o2,o3,out_valid,cnt_gt,cnt_eq,cnt_lt} from a small behavioural model;
//   each test pops and compares once the DUT has clocked. Counter expectations
//   follow ONE_BIT_COMPARATOR_STATS_EN so the bench suits either build.
// -----------------------------------------------------------------------------
module tb_one_bit_comparator;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int VEC_W   = 4 + 3 * CNT_W;

   typedef logic [VEC_W-1:0] vec_t;

   logic             clk;
   logic             rst;
   logic             A;
   logic             B;
   logic             in_valid;
   logic             clr_stats;
   logic             o1;
   logic             o2;
   logic             o3;
   logic             out_valid;
   logic [CNT_W-1:0] cnt_gt;
   logic [CNT_W-1:0] cnt_eq;
   logic [CNT_W-1:0] cnt_lt;

   int   n_tests;
   int   n_fail;
   vec_t sb[$];
   vec_t got;
   vec_t exp_v;

   // Reference model state.
   logic m_o1, m_o2, m_o3, m_vld;
   int   m_gt, m_eq, m_lt;

   one_bit_comparator #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .clr_stats (clr_stats),
      .o1        (o1),
      .o2        (o2),
      .o3        (o3),
      .out_valid (out_valid),
      .cnt_gt    (cnt_gt),
      .cnt_eq    (cnt_eq),
      .cnt_lt    (cnt_lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t model_vec();
      logic [CNT_W-1:0] g, e, l;
      g = CNT_W'(m_gt);
      e = CNT_W'(m_eq);
      l = CNT_W'(m_lt);
      return {m_o1, m_o2, m_o3, m_vld, g, e, l};
   endfunction

   function automatic vec_t dut_vec();
      return {o1, o2, o3, out_valid, cnt_gt, cnt_eq, cnt_lt};
   endfunction

   task automatic model_reset();
      m_o1 = 1'b0; m_o2 = 1'b0; m_o3 = 1'b0; m_vld = 1'b0;
      m_gt = 0; m_eq = 0; m_lt = 0;
   endtask

   // Drive one cycle at the falling edge, predict, push, and step to 1ns past
   // the following rising edge so outputs are sampled away from the edge.
   task automatic drive(input logic a, input logic b, input logic v, input logic c);
      @(negedge clk);
      A = a; B = b; in_valid = v; clr_stats = c;
      if (v) begin
         m_o1 = a & ~b;
         m_o2 = (a == b);
         m_o3 = ~a & b;
         m_vld = 1'b1;
      end
`ifdef ONE_BIT_COMPARATOR_STATS_EN
      if (c) begin
         m_gt = 0; m_eq = 0; m_lt = 0;
      end else if (v) begin
         if (a & ~b && m_gt < CNT_MAX) m_gt++;
         if (a == b && m_eq < CNT_MAX) m_eq++;
         if (~a & b && m_lt < CNT_MAX) m_lt++;
      end
`endif
      sb.push_back(model_vec());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      A = 1'b1; B = 1'b0; in_valid = 1'b1; clr_stats = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      got = dut_vec();
      n_tests++;
      if (got !== model_vec()) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", got, model_vec());
      end else $display("[TB] reset_state vec=%h", got);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_truth_table(input string tag);
      logic [1:0] pat [4];
      pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11;
      for (int i = 0; i < 4; i++) begin
         drive(pat[i][1], pat[i][0], 1'b1, 1'b0);
         got = dut_vec();
         exp_v = sb.pop_front();
         n_tests++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s[%0d] AB=%b got=%h exp=%h", tag, i, pat[i], got, exp_v);
         end else $display("[TB] %s[%0d] AB=%b o=%b%b%b vld=%b", tag, i, pat[i], o1, o2, o3, out_valid);
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(i[0], ~i[0], 1'b0, 1'b0);
         got = dut_vec();
         exp_v = sb.pop_front();
         n_tests++;
         if (got !== exp_v || {o1, o2, o3} !== 3'b100) begin
            n_fail++;
            $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp_v);
         end else $display("[TB] hold[%0d] o=%b%b%b", i, o1, o2, o3);
      end
   endtask

   task automatic test_saturation();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0);
         got = dut_vec();
         exp_v = sb.pop_front();
         n_tests++;
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL saturate[%0d] got=%h exp=%h", i, got, exp_v);
         end else $display("[TB] saturate[%0d] eq=%0d gt=%0d lt=%0d", i, cnt_eq, cnt_gt, cnt_lt);
      end
   endtask

   task automatic test_clear();
      // A couple of gt/lt captures so every counter is nonzero first.
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
      // Clear alone must leave the comparison outputs untouched.
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      got = dut_vec();
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL clear_only got=%h exp=%h", got, exp_v);
      end else $display("[TB] clear_only vec=%h", got);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
      // Clear wins over a simultaneous capture; outputs still update.
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      got = dut_vec();
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v || {o1, o2, o3} !== 3'b001) begin
         n_fail++;
         $display("FAIL clear_with_capture got=%h exp=%h", got, exp_v);
      end else $display("[TB] clear_with_capture vec=%h", got);
      clr_stats = 1'b0;
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
      // Assert reset mid-cycle, away from any rising edge.
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      got = dut_vec();
      n_tests++;
      if (got !== model_vec()) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=%h", got, model_vec());
      end else $display("[TB] async_reset vec=%h", got);
      // Inputs are ignored while reset is held across an edge.
      in_valid = 1'b1; clr_stats = 1'b1; A = 1'b1; B = 1'b1;
      @(posedge clk);
      #1;
      got = dut_vec();
      n_tests++;
      if (got !== model_vec()) begin
         n_fail++;
         $display("FAIL reset_ignores_inputs got=%h exp=%h", got, model_vec());
      end else $display("[TB] reset_ignores_inputs vec=%h", got);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; clr_stats = 1'b0;
      // First capture after release behaves like the very first one.
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      got = dut_vec();
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL first_after_reset got=%h exp=%h", got, exp_v);
      end else $display("[TB] first_after_reset vld=%b gt=%0d", out_valid, cnt_gt);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_truth_table("truth_table");
      test_hold();
      test_saturation();
      test_clear();
      test_async_reset();
      // Fresh reset then repeat the truth table from scratch.
      test_reset();
      test_truth_table("truth_table_rerun");
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
